program_counter: RTL and testbench



---
 rtl/program_counter.sv | 40 ++++
 tb/tb_program_counter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// program_counter
//   Program-counter register of the single-cycle CPU. Holds the address of
//   the instruction being fetched. Every rising clk edge it loads npc
//   exactly as given: it does not align, add to or wrap the value. PC+4 and
//   branch/jump arithmetic happen in the next-PC logic. Holding the PC means
//   the next-PC logic presents npc = out.
//
// Parameters
//   WIDTH       : address width of npc and out
//   RESET_VALUE : reset vector; only the low WIDTH bits are used
//
// Ports
//   clk   in  1      system clock, rising-edge active
//   reset in  1      asynchronous active-low reset (0 = held at reset vector)
//   npc   in  WIDTH  next program-counter value
//   out   out WIDTH  current program-counter value, straight from the register
module program_counter #(
    parameter int unsigned WIDTH       = 32,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] npc,
    output logic [WIDTH-1:0] out
);

    // Reset vector resized to the register width; zero-extended if WIDTH > 32.
    localparam logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VALUE);

    // Reset release is not synchronised here; the system guarantees that
    // release happens away from clk edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= RESET_VEC;
        end else begin
            out <= npc;
        end
    end

endmodule

// File: tb/tb_program_counter.sv
`timescale 1ns/1ps
module tb_program_counter;

    logic        clk;
    logic        reset;
    logic [31:0] npc;
    logic [31:0] out_a;
    logic [31:0] out_b;

    int unsigned checks;
    int unsigned errors;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    program_counter #(
        .WIDTH       (32),
        .RESET_VALUE (32'h0000_0000)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .npc   (npc),
        .out   (out_a)
    );

    program_counter #(
        .WIDTH       (32),
        .RESET_VALUE (32'h0000_3000)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .npc   (npc),
        .out   (out_b)
    );

    // 100 ns period, first rising edge at 50 ns
    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_a(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        qa.push_back(e);
    endtask

    task automatic push_b(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        qb.push_back(e);
    endtask

    task automatic push_both(input string tag, input logic [31:0] va, input logic [31:0] vb);
        push_a({tag, "_a"}, va);
        push_b({tag, "_b"}, vb);
    endtask

    task automatic check_a();
        exp_t e;
        checks++;
        if (qa.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_a_empty observed=%h expected=none", out_a);
        end else begin
            e = qa.pop_front();
            assert (out_a === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, out_a, e.exp);
            end
        end
    endtask

    task automatic check_b();
        exp_t e;
        checks++;
        if (qb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_b_empty observed=%h expected=none", out_b);
        end else begin
            e = qb.pop_front();
            assert (out_b === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, out_b, e.exp);
            end
        end
    endtask

    task automatic check_both();
        check_a();
        check_b();
    endtask

    initial begin
        logic [31:0] seq [4];
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        npc    = 32'h0;

        // Load before any reset: first rising edge at 50 ns loads npc = 0
        push_both("load_before_reset", 32'h0, 32'h0);
        @(posedge clk); #1;
        check_both();

        // Load 0x64
        npc = 32'h64;
        push_both("load_64", 32'h64, 32'h64);
        @(posedge clk); #1;
        check_both();

        // Asynchronous assert mid-cycle with clk low
        @(negedge clk); #10;
        reset = 1'b0;
        push_both("async_assert", 32'h0, 32'h3000);
        #1;
        check_both();

        // Held through two edges while npc = 0x64
        for (int i = 0; i < 2; i++) begin
            push_both("reset_hold", 32'h0, 32'h3000);
            @(posedge clk); #1;
            check_both();
        end

        // Release away from a clk edge: value kept until next rising edge
        @(negedge clk);
        npc = 32'd100;
        #10;
        reset = 1'b1;
        push_both("release_no_edge", 32'h0, 32'h3000);
        #1;
        check_both();
        push_both("first_post_release", 32'd100, 32'd100);
        @(posedge clk); #1;
        check_both();

        // npc changes on falling edges, out follows one edge later
        seq[0] = 32'd104; seq[1] = 32'd108; seq[2] = 32'd112; seq[3] = 32'd116;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            npc = seq[i];
            push_both("seq_load", seq[i], seq[i]);
            #1;
            // no combinational path: out still shows the previous value
            push_both("no_comb_path", (i == 0) ? 32'd100 : seq[i-1],
                                      (i == 0) ? 32'd100 : seq[i-1]);
            qa.push_front(qa.pop_back());
            qb.push_front(qb.pop_back());
            check_both();
            @(posedge clk); #1;
            check_both();
        end

        // Hold via npc = out
        for (int i = 0; i < 3; i++) begin
            push_both("hold_116", 32'd116, 32'd116);
            @(posedge clk); #1;
            check_both();
        end

        // All-ones and misaligned values loaded verbatim
        @(negedge clk);
        npc = 32'hFFFF_FFFF;
        push_both("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check_both();
        @(negedge clk);
        npc = 32'h0000_0002;
        push_both("misaligned", 32'h2, 32'h2);
        @(posedge clk); #1;
        check_both();

        // Reset mid-stream with out = 116 (clk high)
        @(negedge clk);
        npc = 32'd116;
        push_both("reload_116", 32'd116, 32'd116);
        @(posedge clk); #1;
        check_both();
        #10;
        reset = 1'b0;
        push_both("reset_midstream", 32'h0, 32'h3000);
        #1;
        check_both();

        // Release, then assert reset coincident with a rising edge, npc = 0x1234
        @(negedge clk);
        npc = 32'h1234;
        #10;
        reset = 1'b1;
        push_both("release_before_coincident", 32'h0, 32'h3000);
        #1;
        check_both();
        @(posedge clk);
        reset = 1'b0;
        push_both("coincident_reset", 32'h0, 32'h3000);
        #1;
        check_both();

        // Release, first edge loads the then-current npc
        @(negedge clk);
        npc = 32'h000A_BCD0;
        #10;
        reset = 1'b1;
        push_both("release_again", 32'h0, 32'h3000);
        #1;
        check_both();
        push_both("post_release_load", 32'h000A_BCD0, 32'h000A_BCD0);
        @(posedge clk); #1;
        check_both();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
